// File: rtl/display_scan_ctrl.sv
// Avalon-MM scan controller for a multiplexed 7-segment display: per-digit segment
// registers, dwell prescaler and blanking gap, with a registered output stage.
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CNT_W = (DIV_WIDTH > GAP_W) ? DIV_WIDTH : GAP_W;

  localparam logic [2:0]       ADDR_CTRL   = 3'd4;
  localparam logic [2:0]       ADDR_DIV    = 3'd5;
  localparam logic [2:0]       ADDR_STATUS = 3'd6;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [7:0]           digit [NUM_DIGITS];
  logic                 en;
  logic                 blank;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 wr;
  logic                 unused_wdata;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [CNT_W-1:0]     dwell_load;

  logic [7:0]           seg_c;
  logic [NUM_DIGITS-1:0] sel_c;
  logic                 tick_c;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;
  // A programmed divider of zero still dwells for one cycle
  assign dwell_load   = (div_q == '0) ? CNT_ONE : CNT_W'(div_q);

  // Software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) digit[i] <= '0;
      en    <= 1'b0;
      blank <= 1'b0;
      div_q <= '0;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          en    <= writedata[0];
          blank <= writedata[1];
        end
        ADDR_DIV:    div_q <= writedata[DIV_WIDTH-1:0];
        ADDR_STATUS: ;
        default: begin
          for (int i = 0; i < int'(NUM_DIGITS); i++)
            if (address == 3'(i)) digit[i] <= writedata[7:0];
        end
      endcase
    end
  end

  // Zero wait-state read mux
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_CTRL:   readdata = {30'b0, blank, en};
        ADDR_DIV:    readdata = 32'(div_q);
        ADDR_STATUS: begin
          readdata[2:0] = 3'(idx);
          readdata[8]   = (state == DWELL);
        end
        default: begin
          for (int i = 0; i < int'(NUM_DIGITS); i++)
            if (address == 3'(i)) readdata = {24'b0, digit[i]};
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DWELL;
          idx_nxt   = '0;
          cnt_nxt   = dwell_load;
        end
        DWELL: begin
          if (cnt <= CNT_ONE) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt <= CNT_ONE) begin
            state_nxt = DWELL;
            idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            cnt_nxt   = dwell_load;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM outputs; BLANK masks the pins only, never the frame tick
  always_comb begin
    seg_c  = '0;
    sel_c  = '0;
    tick_c = 1'b0;
    if (state == DWELL && !blank) begin
      sel_c = NUM_DIGITS'(1) << idx;
      seg_c = digit[idx];
    end
    if (en && state == GAP && cnt <= CNT_ONE && idx == LAST_IDX) tick_c = 1'b1;
  end

  // Output stage: pins lag the FSM by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out    <= '0;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_c;
      digit_sel  <= sel_c;
      frame_tick <= tick_c;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: per-cycle expected pin values are queued
// as stimulus is issued and compared as the scan produces them.
module tb_display_scan_ctrl;

  localparam int unsigned ND  = 4;
  localparam int unsigned GAP = 2;

  typedef logic [ND+8:0] exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  seg_out;
  logic [ND-1:0] digit_sel;
  logic        frame_tick;

  int          checks = 0;
  int          errors = 0;
  string       phase  = "init";
  exp_t        sb[$];
  logic [7:0]  dig_m [ND];

  display_scan_ctrl #(.NUM_DIGITS(ND), .DIV_WIDTH(16), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] pins();
    return 32'({frame_tick, digit_sel, seg_out});
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s [%s]: observed %h expected %h", tag, phase, o, e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("scan_pins", pins(), 32'(e));
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] e);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    chk(tag, readdata, e);
    chipselect = 1'b0;
  endtask

  task automatic push_zero(input int n);
    for (int k = 0; k < n; k++) sb.push_back('0);
  endtask

  task automatic push_val(input int i, input logic [7:0] v);
    logic [ND-1:0] oh;
    oh = ND'(1) << i;
    sb.push_back({1'b0, oh, v});
  endtask

  // One digit slot: dwell cycles (shown or blanked) then the gap, tick on the frame's last gap cycle
  task automatic push_digit(input int i, input int dwell, input bit show, input bit last);
    for (int k = 0; k < dwell; k++) begin
      if (show) push_val(i, dig_m[i]);
      else      sb.push_back('0);
    end
    for (int k = 0; k < int'(GAP); k++) begin
      if (last && k == int'(GAP) - 1) sb.push_back({1'b1, {ND{1'b0}}, 8'h00});
      else                           sb.push_back('0);
    end
  endtask

  task automatic quiesce();
    bus_write(3'd4, 32'h0);
    repeat (3) tick();
    chk("quiesce_pins", pins(), 32'h0);
    rd_check("quiesce_status", 3'd6, 32'h0);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    dig_m      = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

    // Reset state
    phase = "reset";
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", pins(), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_check("reset_reg", 3'(a), 32'h0);

    // Basic scan, two full frames
    phase = "basic";
    @(posedge clk); #1;
    for (int i = 0; i < int'(ND); i++) bus_write(3'(i), 32'(dig_m[i]));
    bus_write(3'd5, 32'd3);
    push_zero(2);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < int'(ND); i++) push_digit(i, 3, 1'b1, i == int'(ND) - 1);
    bus_write(3'd4, 32'h1);
    repeat (41) tick();

    // Disable during digit 2 dwell
    phase = "disable";
    push_digit(0, 3, 1'b1, 1'b0);
    push_digit(1, 3, 1'b1, 1'b0);
    push_val(2, dig_m[2]);
    push_val(2, dig_m[2]);
    push_zero(3);
    repeat (10) tick();
    bus_write(3'd4, 32'h0);
    repeat (4) tick();
    rd_check("disable_status", 3'd6, 32'h0);

    // Re-enable restarts at digit 0
    phase = "reenable";
    push_zero(2);
    for (int i = 0; i < int'(ND); i++) push_digit(i, 3, 1'b1, i == int'(ND) - 1);
    bus_write(3'd4, 32'h1);
    repeat (21) tick();
    quiesce();

    // DIV=0 dwells one cycle; DIV=5 written during that dwell applies from the next digit
    phase = "div";
    bus_write(3'd5, 32'd0);
    push_zero(2);
    push_digit(0, 1, 1'b1, 1'b0);
    push_digit(1, 5, 1'b1, 1'b0);
    push_digit(2, 5, 1'b1, 1'b0);
    push_digit(3, 5, 1'b1, 1'b1);
    bus_write(3'd4, 32'h1);
    tick();
    bus_write(3'd5, 32'd5);
    repeat (23) tick();
    quiesce();

    // BLANK hides pins while idx and frame_tick keep going
    phase = "blank";
    bus_write(3'd5, 32'd2);
    push_zero(2);
    for (int i = 0; i < int'(ND); i++) push_digit(i, 2, 1'b0, i == int'(ND) - 1);
    bus_write(3'd4, 32'h3);
    repeat (9) tick();
    rd_check("blank_status_d2", 3'd6, 32'h102);
    repeat (8) tick();
    rd_check("blank_status_d0", 3'd6, 32'h100);
    push_zero(5);
    push_digit(1, 1, 1'b1, 1'b0);
    push_digit(2, 2, 1'b1, 1'b0);
    push_digit(3, 2, 1'b1, 1'b1);
    repeat (4) tick();
    rd_check("blank_status_d1", 3'd6, 32'h101);
    bus_write(3'd4, 32'h1);
    repeat (11) tick();
    quiesce();

    // Register access and live digit update
    phase = "regs";
    bus_write(3'd1, 32'hA5);
    rd_check("rd_digit1", 3'd1, 32'hA5);
    bus_write(3'd2, 32'hFFFF_FF12);
    rd_check("rd_digit2_upper0", 3'd2, 32'h12);
    bus_write(3'd7, 32'hFFFF_FFFF);
    rd_check("rd_unmapped", 3'd7, 32'h0);
    rd_check("rd_digit0", 3'd0, 32'h3F);
    bus_write(3'd5, 32'h1_0004);
    rd_check("rd_div", 3'd5, 32'h4);
    bus_write(3'd4, 32'hFFFF_FFF3);
    rd_check("rd_ctrl", 3'd4, 32'h3);
    quiesce();
    dig_m[1] = 8'hA5;
    dig_m[2] = 8'h12;

    phase = "live_digit";
    push_zero(2);
    push_digit(0, 4, 1'b1, 1'b0);
    push_val(1, 8'hA5);
    push_val(1, 8'hA5);
    push_val(1, 8'h77);
    push_val(1, 8'h77);
    push_zero(2);
    push_digit(2, 4, 1'b1, 1'b0);
    bus_write(3'd4, 32'h1);
    repeat (8) tick();
    bus_write(3'd1, 32'h77);
    repeat (10) tick();

    // Asynchronous reset during digit 3 dwell
    phase = "async_reset";
    repeat (2) tick();
    chk("pre_reset_pins", pins(), 32'({1'b0, 4'b1000, 8'h4F}));
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pins", pins(), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_check("post_reset_reg", 3'(a), 32'h0);
    repeat (3) tick();
    chk("post_reset_pins", pins(), 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
